// File: rtl/uart_tx_feeder_if.sv
// Producer/UART-facing signal bundle of uart_tx_feeder.
// master = producer + UART side, slave = the feeder.
interface uart_tx_feeder_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              pause;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              busy;
  logic              uart_transmit;
  logic [7:0]        uart_tx_byte;
  logic              uart_is_transmitting;

  modport master (
    output wr_en, wr_data, pause, uart_is_transmitting,
    input  full, empty, level, overflow, busy, uart_transmit, uart_tx_byte
  );

  modport slave (
    input  wr_en, wr_data, pause, uart_is_transmitting,
    output full, empty, level, overflow, busy, uart_transmit, uart_tx_byte
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding an 8N2 UART transmitter; launches one byte at a time,
// paced by the UART's is_transmitting flag.
module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_feeder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_e;

  state_e              state_q, state_d;
  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   rptr_q, rptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                overflow_q, overflow_d;
  logic                busy_q, busy_d;
  logic                transmit_q, transmit_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                push, pop;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    transmit_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    pop        = 1'b0;
    // Room is judged on the registered full flag; a same-cycle pop does not help.
    push       = bus.wr_en & ~full_q;

    unique case (state_q)
      IDLE: begin
        if (!empty_q && !bus.pause && !bus.uart_is_transmitting) begin
          pop        = 1'b1;
          tx_byte_d  = mem_q[rptr_q];
          transmit_d = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        if (bus.uart_is_transmitting) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!bus.uart_is_transmitting) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wptr_d     = wptr_q + ADDR_W'(push);
    rptr_d     = rptr_q + ADDR_W'(pop);
    level_d    = level_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    full_d     = (level_d == (ADDR_W+1)'(DEPTH));
    empty_d    = (level_d == '0);
    overflow_d = bus.wr_en & full_q;
    busy_d     = (state_d != IDLE) | ~empty_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and level
  // define which entries are valid, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wptr_q] <= bus.wr_data;
  end

  assign bus.full          = full_q;
  assign bus.empty         = empty_q;
  assign bus.level         = level_q;
  assign bus.overflow      = overflow_q;
  assign bus.busy          = busy_q;
  assign bus.uart_transmit = transmit_q;
  assign bus.uart_tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small behavioural 8N2 UART
// (2 clk per bit) standing in for the real transmitter.
module tb_uart_tx_feeder;

  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int BIT_CLKS = 2;

  logic clk;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  uart_tx_feeder_if #(.ADDR_W(ADDR_W)) tx_if ();

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (tx_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural UART: samples transmit at an edge, is_transmitting rises
  // after that edge, shifts start + 8 data (LSB first) + 2 stop bits.
  logic        uart_busy;
  logic [10:0] shreg;
  logic [10:0] frame_cur;
  int          bit_n, sub_n;
  logic [7:0]  sent_q[$];
  logic [10:0] frames_q[$];

  assign tx_if.uart_is_transmitting = uart_busy;

  always @(posedge clk) begin
    if (!rst) begin
      uart_busy <= 1'b0;
      shreg     <= '1;
      bit_n     <= 0;
      sub_n     <= 0;
    end else if (!uart_busy) begin
      if (tx_if.uart_transmit) begin
        uart_busy <= 1'b1;
        shreg     <= {2'b11, tx_if.uart_tx_byte, 1'b0};
        bit_n     <= 0;
        sub_n     <= 0;
        sent_q.push_back(tx_if.uart_tx_byte);
      end
    end else begin
      if (sub_n == 0) frame_cur[bit_n] <= shreg[0];
      if (sub_n == BIT_CLKS-1) begin
        sub_n <= 0;
        shreg <= {1'b1, shreg[10:1]};
        if (bit_n == 10) begin
          uart_busy <= 1'b0;
          frames_q.push_back(frame_cur);
        end else begin
          bit_n <= bit_n + 1;
        end
      end else begin
        sub_n <= sub_n + 1;
      end
    end
  end

  // Launch protocol: never two strobes in a row, never while the UART is busy.
  logic prev_tx = 1'b0;
  always @(negedge clk) begin
    if (tx_if.uart_transmit) begin
      total++;
      assert (!prev_tx && !tx_if.uart_is_transmitting) passed++;
      else $error("FAIL launch_protocol: observed prev=%0b is_tx=%0b expected prev=0 is_tx=0",
                  prev_tx, tx_if.uart_is_transmitting);
    end
    prev_tx = tx_if.uart_transmit;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet(input string tag, input int limit);
    int n = 0;
    while ((tx_if.busy || uart_busy) && n < limit) begin
      tick();
      n++;
    end
    check(tag, 32'(n < limit), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int peak;
    int n;
    logic seen;

    rst = 1'b0;
    tx_if.wr_en = 1'b0;
    tx_if.wr_data = 8'h00;
    tx_if.pause = 1'b0;
    tick();
    tick();
    check("rst_level",    32'(tx_if.level),        32'd0);
    check("rst_empty",    32'(tx_if.empty),        32'd1);
    check("rst_full",     32'(tx_if.full),         32'd0);
    check("rst_overflow", 32'(tx_if.overflow),     32'd0);
    check("rst_busy",     32'(tx_if.busy),         32'd0);
    check("rst_transmit", 32'(tx_if.uart_transmit), 32'd0);
    check("rst_tx_byte",  32'(tx_if.uart_tx_byte), 32'h00);
    rst = 1'b1;

    // Single byte A5
    tx_if.wr_en = 1'b1; tx_if.wr_data = 8'hA5; tick(); tx_if.wr_en = 1'b0;
    check("t1_level_after_write", 32'(tx_if.level), 32'd1);
    check("t1_empty_after_write", 32'(tx_if.empty), 32'd0);
    tick();
    check("t1_transmit", 32'(tx_if.uart_transmit), 32'd1);
    check("t1_tx_byte",  32'(tx_if.uart_tx_byte),  32'hA5);
    check("t1_level_after_pop", 32'(tx_if.level),  32'd0);
    check("t1_empty_after_pop", 32'(tx_if.empty),  32'd1);
    check("t1_busy_in_flight",  32'(tx_if.busy),   32'd1);
    tick();
    check("t1_transmit_one_cycle", 32'(tx_if.uart_transmit), 32'd0);
    check("t1_tx_byte_held",       32'(tx_if.uart_tx_byte),  32'hA5);
    wait_quiet("t1_busy_drops", 100);
    check("t1_frame_count", 32'(frames_q.size()), 32'd1);
    // {stop,stop, A5, start} = 11'b11_10100101_0
    if (frames_q.size() > 0) check("t1_frame_bits", 32'(frames_q[0]), 32'h74A);
    frames_q.delete();
    sent_q.delete();

    // Burst 01, 02, 03
    peak = 0;
    tx_if.wr_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tx_if.wr_data = 8'(i);
      tick();
      if (int'(tx_if.level) > peak) peak = int'(tx_if.level);
    end
    tx_if.wr_en = 1'b0;
    tick();
    if (int'(tx_if.level) > peak) peak = int'(tx_if.level);
    check("t2_peak_level", 32'(peak >= 2 && peak <= 3), 32'd1);
    wait_quiet("t2_done", 300);
    check("t2_sent_count", 32'(sent_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < sent_q.size(); i++)
      check("t2_order", 32'(sent_q[i]), 32'(i + 1));
    sent_q.delete();

    // Full / overflow with pause held
    tx_if.pause = 1'b1;
    tx_if.wr_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tx_if.wr_data = 8'(i);
      tick();
      if (i == 15) begin
        check("t3_full_at_16",     32'(tx_if.full),     32'd1);
        check("t3_level_at_16",    32'(tx_if.level),    32'd16);
        check("t3_no_overflow_16", 32'(tx_if.overflow), 32'd0);
      end
    end
    check("t3_overflow_pulse", 32'(tx_if.overflow), 32'd1);
    check("t3_level_stays",    32'(tx_if.level),    32'd16);
    tx_if.wr_en = 1'b0;
    tick();
    check("t3_overflow_one_cycle", 32'(tx_if.overflow), 32'd0);
    check("t3_level_still_16",     32'(tx_if.level),    32'd16);
    tx_if.pause = 1'b0;
    wait_quiet("t3_done", 16 * 30);
    check("t3_sent_count", 32'(sent_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < sent_q.size(); i++)
      check("t3_order", 32'(sent_q[i]), 32'(i));
    sent_q.delete();

    // Pointers sit at 4: 14 writes wrap wptr past DEPTH-1, then push+pop together
    tx_if.pause = 1'b1;
    tx_if.wr_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tx_if.wr_data = 8'h20 + 8'(i);
      tick();
    end
    check("t4_level_before", 32'(tx_if.level), 32'd14);
    tx_if.wr_data = 8'h2E;
    tx_if.pause = 1'b0;
    tick();
    tx_if.wr_en = 1'b0;
    check("t4_launch",        32'(tx_if.uart_transmit), 32'd1);
    check("t4_launch_byte",   32'(tx_if.uart_tx_byte),  32'h20);
    check("t4_level_same",    32'(tx_if.level),         32'd14);
    wait_quiet("t4_done", 15 * 30);
    check("t4_sent_count", 32'(sent_q.size()), 32'd15);
    for (int i = 0; i < 15 && i < sent_q.size(); i++)
      check("t4_order", 32'(sent_q[i]), 32'h20 + 32'(i));
    sent_q.delete();

    // Pause mid-byte
    tx_if.wr_en = 1'b1; tx_if.wr_data = 8'h3C; tick();
    tx_if.wr_data = 8'h3D; tick();
    tx_if.wr_en = 1'b0;
    check("t5_launch_3c", 32'(tx_if.uart_tx_byte), 32'h3C);
    n = 0;
    while (!uart_busy && n < 10) begin tick(); n++; end
    check("t5_uart_started", 32'(n < 10), 32'd1);
    tick();
    tx_if.pause = 1'b1;
    n = 0;
    while (uart_busy && n < 40) begin tick(); n++; end
    check("t5_3c_completes", 32'(n < 40), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | tx_if.uart_transmit;
    end
    check("t5_held_by_pause", 32'(seen),               32'd0);
    check("t5_3d_queued",     32'(tx_if.level),        32'd1);
    check("t5_sent_only_3c",  32'(sent_q.size()),      32'd1);
    tx_if.pause = 1'b0;
    tick();
    check("t5_launch_after_pause", 32'(tx_if.uart_transmit), 32'd1);
    check("t5_launch_3d",          32'(tx_if.uart_tx_byte),  32'h3D);
    wait_quiet("t5_done", 100);
    sent_q.delete();
    frames_q.delete();

    // Reset mid-transfer with 4 queued
    tx_if.wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_if.wr_data = 8'h70 + 8'(i);
      tick();
    end
    tx_if.wr_en = 1'b0;
    n = 0;
    while (!uart_busy && n < 10) begin tick(); n++; end
    tick();
    check("t6_level_before_rst", 32'(tx_if.level), 32'd4);
    rst = 1'b0;
    tx_if.wr_en = 1'b1;
    tx_if.wr_data = 8'hFF;
    tick();
    check("t6_rst_level",    32'(tx_if.level),          32'd0);
    check("t6_rst_empty",    32'(tx_if.empty),          32'd1);
    check("t6_rst_transmit", 32'(tx_if.uart_transmit),  32'd0);
    check("t6_rst_tx_byte",  32'(tx_if.uart_tx_byte),   32'h00);
    check("t6_rst_busy",     32'(tx_if.busy),           32'd0);
    check("t6_rst_uart",     32'(tx_if.uart_is_transmitting), 32'd0);
    tick();
    check("t6_wr_in_rst_ignored", 32'(tx_if.level), 32'd0);
    rst = 1'b1;
    tx_if.wr_en = 1'b0;
    tick();
    sent_q.delete();
    frames_q.delete();
    tx_if.wr_en = 1'b1; tx_if.wr_data = 8'h5A; tick(); tx_if.wr_en = 1'b0;
    tick();
    check("t6_fresh_launch", 32'(tx_if.uart_transmit), 32'd1);
    check("t6_fresh_byte",   32'(tx_if.uart_tx_byte),  32'h5A);
    wait_quiet("t6_done", 100);
    check("t6_sent_count", 32'(sent_q.size()), 32'd1);
    // {stop,stop, 5A, start} = 11'b11_01011010_0
    if (frames_q.size() > 0) check("t6_frame_bits", 32'(frames_q[0]), 32'h6B4);
    else check("t6_frame_count", 32'(frames_q.size()), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
